// File: rtl/tt_um_serial_subtractor_pkg.sv
// Shared constants and types for the bit-serial 8-bit subtractor.
package tt_um_serial_subtractor_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  // uio_in control bits
  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;

  // uio_out status bits
  localparam int BUSY   = 7;
  localparam int DONE   = 6;
  localparam int BORROW = 5;

  localparam logic [7:0] UIO_OE = 8'b1110_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/tt_um_serial_subtractor_if.sv
// Pin-level bundle of the subtractor: enable, operand/control inputs, result/status outputs.
interface tt_um_serial_subtractor_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow into the next bit.
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial A-B: operands latched by load strobes, LSB-first over WIDTH cycles after start.
module tt_um_serial_subtractor
  import tt_um_serial_subtractor_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  tt_um_serial_subtractor_if.slave   io
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] dsh_q, dsh_d, res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_d, bit_bout;
  logic [7:0]       status;
  logic             unused_uio;

  assign unused_uio = &{1'b0, io.uio_in[7:3]};

  serial_sub_cell u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dsh_d    = dsh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over any load strobe in the same cycle
        if (io.uio_in[START]) begin
          state_d  = S_RUN;
          sa_d     = a_q;
          sb_d     = b_q;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end else begin
          if (io.uio_in[LOAD_A]) a_d = io.ui_in;
          if (io.uio_in[LOAD_B]) b_d = io.ui_in;
        end
      end
      S_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        dsh_d    = {bit_d, dsh_q[WIDTH-1:1]};
        borrow_d = bit_bout;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d   = dsh_d;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      dsh_q    <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (io.ena) begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dsh_q    <= dsh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    status         = '0;
    status[BUSY]   = (state_q == S_RUN);
    status[DONE]   = (state_q == S_DONE);
    status[BORROW] = borrow_q;
  end

  assign io.uo_out  = res_q;
  assign io.uio_out = status;
  assign io.uio_oe  = UIO_OE;
endmodule

// File: doc/tt_um_serial_subtractor.md
TT_UM_SERIAL_SUBTRACTOR -- requirements
Module: tt_um_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width; fixed by the 8-bit pin buses.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: ena  input  1  design enable; when low, all registers SHALL hold.
REQ-005 Port: ui_in  input  8  operand data bus, A or B.
REQ-006 Port: uio_in  input  8  bit0 load_a, bit1 load_b, bit2 start, all active-high; bits 7:3 unused.
REQ-007 Port: uo_out  output  8  result register (A - B) mod 256.
REQ-008 Port: uio_out  output  8  bit7 busy, bit6 done, bit5 borrow; bits 4:0 SHALL be 0.
REQ-009 Port: uio_oe  output  8  SHALL be constant 8'b1110_0000.

Function
REQ-010 Registers: a_q, b_q (operands), sa, sb (shift copies), dsh (difference shift), res_q, borrow_q, cnt (3 bits), state.
REQ-011 States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
REQ-012 IDLE/DONE, ena=1, start=0: load_a captures ui_in into a_q; load_b captures ui_in into b_q; both may assert in one cycle.
REQ-013 IDLE/DONE, ena=1, start=1: go to RUN, sa<=a_q, sb<=b_q, borrow_q<=0, cnt<=0; any load in that cycle is ignored.
REQ-014 RUN per cycle: d = sa[0]^sb[0]^borrow_q; borrow_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow_q); sa, sb shift right; d shifts into dsh MSB.
REQ-015 RUN on cnt==7: res_q <= final 8-bit difference including the current bit; borrow flag <= borrow_next; go to DONE; else cnt increments.
REQ-016 Latency: start sampled at edge k; busy high after edges k..k+7; done and new uo_out visible after edge k+8.
REQ-017 RUN ignores load_a, load_b and start.
REQ-018 DONE holds res_q, borrow and done until the next start; loads in DONE do not clear done.
REQ-019 a_q/b_q are never modified by a computation; repeated start without reload SHALL reproduce the same result.
REQ-020 ena=0 in any state freezes state, counter and all registers, stretching RUN by the number of disabled cycles.
REQ-021 uo_out changes only on entry to DONE, never mid-RUN.
REQ-022 borrow = 1 iff A < B, unsigned.

Reset
REQ-023 rst_n low asynchronously forces state=IDLE and zeroes a_q, b_q, sa, sb, dsh, res_q, borrow_q and cnt.
REQ-024 During reset uo_out=0x00, uio_out=0x00, uio_oe=0xE0; reset mid-RUN aborts with no DONE.

Structure
REQ-025 Shared package: state enum, WIDTH, control bit indices (LOAD_A=0, LOAD_B=1, START=2) and status bit indices (BUSY=7, DONE=6, BORROW=5).
REQ-026 One combinational sub-module, serial_sub_cell (a, b, bin -> d, bout), implements REQ-014 and is instantiated once.

Verification
REQ-027 load_a with ui_in=0x05, load_b with ui_in=0x03, then start -> busy 8 cycles; then uo_out=0x02, borrow=0, done=1.
REQ-028 A=0x03, B=0x05, start -> uo_out=0xFE, borrow=1; A=0x00, B=0x01 -> uo_out=0xFF, borrow=1.
REQ-029 A=B=0xAA, start twice in a row without reload -> both runs give uo_out=0x00, borrow=0; loads pulsed during RUN change nothing.
REQ-030 ena low for 3 cycles mid-RUN -> done appears after edge k+11; result unchanged.
REQ-031 rst_n low at RUN cycle 4 -> immediate IDLE, all outputs 0, uio_oe=0xE0; a fresh load/start then computes correctly.
REQ-032 start with load_a asserted, ui_in=0xFF -> load ignored; result uses the previous a_q.
